// File: rtl/issue_buffer_pkg.sv
// Shared definitions for the in-order issue buffer: packed entry layout,
// control-word bit positions and slot-requirement decoding.
package issue_buffer_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 8;
  localparam int REG_W  = 5;

  // Control-word bit positions
  localparam int CTRL_ISSUE_PRI  = 0;
  localparam int CTRL_ISSUE_SLOT = 1;
  localparam int CTRL_REGWRITE   = 2;
  localparam int CTRL_RS1_ACTIVE = 3;
  localparam int CTRL_RS2_ACTIVE = 4;

  // Register specifiers sit at their RISC-V positions in the instruction word
  localparam int INST_RD_LSB  = 7;
  localparam int INST_RS1_LSB = 15;
  localparam int INST_RS2_LSB = 20;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pred_tgt;
    logic              pred;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   inst;
  } entry_t;

  localparam int ENTRY_W  = $bits(entry_t);
  localparam int OFF_INST = 0;
  localparam int OFF_CTRL = OFF_INST + XLEN;
  localparam int OFF_PRED = OFF_CTRL + CTRL_W;
  localparam int OFF_TGT  = OFF_PRED + 1;
  localparam int OFF_PC   = OFF_TGT + XLEN;

  typedef enum logic [1:0] {
    REQ_ANY = 2'd0,
    REQ_P0  = 2'd1,
    REQ_P1  = 2'd2
  } slot_req_t;

  function automatic slot_req_t slot_req(input logic [CTRL_W-1:0] ctrl);
    if (!ctrl[CTRL_ISSUE_PRI]) return REQ_ANY;
    return ctrl[CTRL_ISSUE_SLOT] ? REQ_P1 : REQ_P0;
  endfunction

  function automatic logic [REG_W-1:0] inst_rd(input logic [XLEN-1:0] inst);
    return inst[INST_RD_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] inst_rs1(input logic [XLEN-1:0] inst);
    return inst[INST_RS1_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] inst_rs2(input logic [XLEN-1:0] inst);
    return inst[INST_RS2_LSB +: REG_W];
  endfunction

endpackage

// File: rtl/issue_buffer_steer.sv
// Pair-issue decision for the two oldest entries: which issue, on which pipe,
// and how many leave the queue.
module issue_steer
  import issue_buffer_pkg::*;
(
  input  entry_t     a,
  input  entry_t     b,
  input  logic       a_valid,
  input  logic       b_valid,
  input  logic       flush,
  output logic [1:0] iss_valid,
  output logic       swap,
  output logic [1:0] deq_count,
  output entry_t     pipe0_entry,
  output entry_t     pipe1_entry
);

  slot_req_t req_a;
  slot_req_t req_b;
  logic      dep_rs1;
  logic      dep_rs2;
  logic      dep;
  logic      same_pipe;

  assign req_a = slot_req(a.ctrl);
  assign req_b = slot_req(b.ctrl);

  // x0 never carries a value, so reading it cannot create a hazard
  assign dep_rs1 = b.ctrl[CTRL_RS1_ACTIVE] && (inst_rs1(b.inst) != '0)
                   && (inst_rs1(b.inst) == inst_rd(a.inst));
  assign dep_rs2 = b.ctrl[CTRL_RS2_ACTIVE] && (inst_rs2(b.inst) != '0)
                   && (inst_rs2(b.inst) == inst_rd(a.inst));
  assign dep     = a.ctrl[CTRL_REGWRITE] && (dep_rs1 || dep_rs2);

  assign same_pipe = (req_a != REQ_ANY) && (req_a == req_b);

  always_comb begin
    iss_valid = 2'b00;
    swap      = 1'b0;
    deq_count = 2'd0;
    if (!flush && a_valid) begin
      if (b_valid && !dep && !same_pipe) begin
        iss_valid = 2'b11;
        deq_count = 2'd2;
        swap      = (req_a == REQ_P1) || (req_b == REQ_P0);
      end else begin
        deq_count = 2'd1;
        if (req_a == REQ_P1) begin
          iss_valid = 2'b10;
          swap      = 1'b1;
        end else begin
          iss_valid = 2'b01;
        end
      end
    end
  end

  assign pipe0_entry = swap ? b : a;
  assign pipe1_entry = swap ? a : b;

endmodule

// File: rtl/issue_buffer.sv
// In-order dual-issue queue between decode and the two execute pipes.
// Circular storage with explicit occupancy count; head pair is steered each cycle.
module issue_buffer
  import issue_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 flush_i,
  input  logic [1:0]           enq_valid_i,
  input  logic [2*ENTRY_W-1:0] enq_entry_i,
  output logic                 enq_ready_o,
  input  logic                 iss_ready_i,
  output logic [1:0]           iss_valid_o,
  output logic [2*ENTRY_W-1:0] iss_entry_o,
  output logic                 iss_swap_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t         mem [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CW-1:0]  count;

  entry_t         lane0;
  entry_t         lane1;
  logic           enq_fire;
  logic [CW-1:0]  enq_count;
  logic [CW-1:0]  commit_count;

  entry_t         cand_a;
  entry_t         cand_b;
  logic [1:0]     deq_count;
  entry_t         pipe0_entry;
  entry_t         pipe1_entry;

  assign lane0 = entry_t'(enq_entry_i[ENTRY_W-1:0]);
  assign lane1 = entry_t'(enq_entry_i[2*ENTRY_W-1:ENTRY_W]);

  // Ready ignores this cycle's dequeue so it stays off the issue path
  assign enq_ready_o = (count <= CW'(DEPTH - 2));
  assign enq_fire    = enq_ready_o && enq_valid_i[0] && !flush_i;
  assign enq_count   = !enq_fire ? '0 : (enq_valid_i[1] ? CW'(2) : CW'(1));

  assign cand_a = mem[head];
  assign cand_b = mem[head + PW'(1)];

  issue_steer u_steer (
    .a           (cand_a),
    .b           (cand_b),
    .a_valid     (count >= CW'(1)),
    .b_valid     (count >= CW'(2)),
    .flush       (flush_i),
    .iss_valid   (iss_valid_o),
    .swap        (iss_swap_o),
    .deq_count   (deq_count),
    .pipe0_entry (pipe0_entry),
    .pipe1_entry (pipe1_entry)
  );

  assign commit_count = iss_ready_i ? CW'(deq_count) : '0;
  assign iss_entry_o  = {pipe1_entry, pipe0_entry};
  assign count_o      = count;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(commit_count);
      tail  <= tail + PW'(enq_count);
      count <= count + enq_count - commit_count;
    end
  end

  // Payload storage is deliberately left unreset; count qualifies every read
  always_ff @(posedge clock_i) begin
    if (enq_fire) begin
      mem[tail] <= lane0;
      if (enq_valid_i[1]) begin
        mem[tail + PW'(1)] <= lane1;
      end
    end
  end

endmodule

// File: tb/tb_issue_buffer.sv
// Directed bench for issue_buffer: pairing rules, slot steering, fill/wrap,
// concurrent enqueue/issue, flush and asynchronous reset.
module tb_issue_buffer;
  import issue_buffer_pkg::*;

  logic                 clock_i;
  logic                 reset_i;
  logic                 flush_i;
  logic [1:0]           enq_valid_i;
  logic [2*ENTRY_W-1:0] enq_entry_i;
  logic                 enq_ready_o;
  logic                 iss_ready_i;
  logic [1:0]           iss_valid_o;
  logic [2*ENTRY_W-1:0] iss_entry_o;
  logic                 iss_swap_o;
  logic [3:0]           count_o;

  int checks = 0;
  int errors = 0;

  issue_buffer #(.DEPTH(8)) dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .flush_i     (flush_i),
    .enq_valid_i (enq_valid_i),
    .enq_entry_i (enq_entry_i),
    .enq_ready_o (enq_ready_o),
    .iss_ready_i (iss_ready_i),
    .iss_valid_o (iss_valid_o),
    .iss_entry_o (iss_entry_o),
    .iss_swap_o  (iss_swap_o),
    .count_o     (count_o)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  function automatic entry_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic pri, input logic slot, input logic rw,
                                input logic r1a, input logic r2a);
    entry_t e;
    e = '0;
    e.pc       = pc;
    e.pred_tgt = pc + 32'd8;
    e.ctrl[CTRL_ISSUE_PRI]  = pri;
    e.ctrl[CTRL_ISSUE_SLOT] = slot;
    e.ctrl[CTRL_REGWRITE]   = rw;
    e.ctrl[CTRL_RS1_ACTIVE] = r1a;
    e.ctrl[CTRL_RS2_ACTIVE] = r2a;
    e.inst = {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
    return e;
  endfunction

  function automatic entry_t alu(input logic [31:0] pc);
    return mk(pc, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] v, input entry_t e0, input entry_t e1,
                               input logic rdy, input logic fl);
    enq_valid_i = v;
    enq_entry_i = {e1, e0};
    iss_ready_i = rdy;
    flush_i     = fl;
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] ev, input logic es,
                             input logic [3:0] ec, input logic er);
    checkValue({tag, ".valid"}, 32'(iss_valid_o), 32'(ev));
    checkValue({tag, ".swap"},  32'(iss_swap_o),  32'(es));
    checkValue({tag, ".count"}, 32'(count_o),     32'(ec));
    checkValue({tag, ".ready"}, 32'(enq_ready_o), 32'(er));
  endtask

  task automatic checkPipe(input string tag, input int pipe, input logic [31:0] pc);
    entry_t e;
    if (pipe == 0) e = entry_t'(iss_entry_o[ENTRY_W-1:0]);
    else           e = entry_t'(iss_entry_o[2*ENTRY_W-1:ENTRY_W]);
    checkValue({tag, ".pc"}, e.pc, pc);
  endtask

  entry_t idle;
  entry_t junk;

  initial begin
    idle = '0;
    junk = alu(32'hDEAD);
    reset_i = 1'b1;
    flush_i = 1'b0;
    enq_valid_i = 2'b00;
    enq_entry_i = '0;
    iss_ready_i = 1'b0;
    #3;
    checkOutput("reset", 2'b00, 1'b0, 4'd0, 1'b1);
    #4 reset_i = 1'b0;
    tick();

    // Two independent ALU ops dual issue, in order
    applyStimulus(2'b11, mk(32'h100, 5'd1, 5'd3, 5'd4, 0, 0, 1, 1, 1),
                         mk(32'h104, 5'd2, 5'd5, 5'd6, 0, 0, 1, 1, 1), 1, 0);
    checkOutput("enq_latency", 2'b00, 1'b0, 4'd0, 1'b1);
    tick();
    applyStimulus(2'b00, idle, idle, 1, 0);
    checkOutput("dual_any", 2'b11, 1'b0, 4'd2, 1'b1);
    checkPipe("dual_any.p0", 0, 32'h100);
    checkPipe("dual_any.p1", 1, 32'h104);
    tick();
    checkOutput("dual_drained", 2'b00, 1'b0, 4'd0, 1'b1);

    // RAW: add x5,x1,x2 ; sub x6,x5,x3
    applyStimulus(2'b11, mk(32'h108, 5'd5, 5'd1, 5'd2, 0, 0, 1, 1, 1),
                         mk(32'h10C, 5'd6, 5'd5, 5'd3, 0, 0, 1, 1, 1), 1, 0);
    tick();
    applyStimulus(2'b00, idle, idle, 1, 0);
    checkOutput("raw_a", 2'b01, 1'b0, 4'd2, 1'b1);
    checkPipe("raw_a.p0", 0, 32'h108);
    tick();
    checkOutput("raw_b", 2'b01, 1'b0, 4'd1, 1'b1);
    checkPipe("raw_b.p0", 0, 32'h10C);
    tick();

    // Writing and reading x0 is not a hazard
    applyStimulus(2'b11, mk(32'h110, 5'd0, 5'd1, 5'd2, 0, 0, 1, 1, 1),
                         mk(32'h114, 5'd7, 5'd0, 5'd0, 0, 0, 1, 1, 1), 1, 0);
    tick();
    applyStimulus(2'b00, idle, idle, 1, 0);
    checkOutput("x0_dual", 2'b11, 1'b0, 4'd2, 1'b1);
    tick();

    // A needs P1, B anywhere: swapped dual issue
    applyStimulus(2'b11, mk(32'h118, 5'd8, 5'd1, 5'd2, 1, 1, 1, 1, 1),
                         mk(32'h11C, 5'd9, 5'd3, 5'd4, 0, 0, 1, 1, 1), 1, 0);
    tick();
    applyStimulus(2'b00, idle, idle, 1, 0);
    checkOutput("p1_any", 2'b11, 1'b1, 4'd2, 1'b1);
    checkPipe("p1_any.p0", 0, 32'h11C);
    checkPipe("p1_any.p1", 1, 32'h118);
    tick();

    // Both need P1: serialised on pipe1
    applyStimulus(2'b11, mk(32'h120, 5'd10, 5'd1, 5'd2, 1, 1, 1, 1, 1),
                         mk(32'h124, 5'd11, 5'd3, 5'd4, 1, 1, 1, 1, 1), 1, 0);
    tick();
    applyStimulus(2'b00, idle, idle, 1, 0);
    checkOutput("p1_p1_a", 2'b10, 1'b1, 4'd2, 1'b1);
    checkPipe("p1_p1_a.p1", 1, 32'h120);
    tick();
    checkOutput("p1_p1_b", 2'b10, 1'b1, 4'd1, 1'b1);
    checkPipe("p1_p1_b.p1", 1, 32'h124);
    tick();
    checkOutput("p1_p1_empty", 2'b00, 1'b0, 4'd0, 1'b1);

    // Fill with issue frozen; head sits at index 2 so the fill wraps 7->0
    applyStimulus(2'b11, alu(32'h200), alu(32'h204), 0, 0);
    tick();
    applyStimulus(2'b10, junk, junk, 0, 0);
    checkOutput("frozen", 2'b11, 1'b0, 4'd2, 1'b1);
    tick();
    checkValue("illegal_10.count", 32'(count_o), 32'd2);
    applyStimulus(2'b11, alu(32'h208), alu(32'h20C), 0, 0);
    tick();
    applyStimulus(2'b11, alu(32'h210), alu(32'h214), 0, 0);
    tick();
    checkOutput("fill6", 2'b11, 1'b0, 4'd6, 1'b1);
    applyStimulus(2'b01, alu(32'h218), junk, 0, 0);
    tick();
    applyStimulus(2'b11, junk, junk, 0, 0);
    checkOutput("fill7", 2'b11, 1'b0, 4'd7, 1'b0);
    checkPipe("fill7.p0", 0, 32'h200);
    tick();
    applyStimulus(2'b00, idle, idle, 1, 0);
    checkOutput("full_reject", 2'b11, 1'b0, 4'd7, 1'b0);
    checkPipe("drain1.p0", 0, 32'h200);
    checkPipe("drain1.p1", 1, 32'h204);
    tick();
    checkValue("drain2.count", 32'(count_o), 32'd5);
    checkPipe("drain2.p0", 0, 32'h208);
    checkPipe("drain2.p1", 1, 32'h20C);
    tick();
    checkPipe("drain3.p0", 0, 32'h210);
    checkPipe("drain3.p1", 1, 32'h214);
    tick();
    checkOutput("drain_wrap", 2'b01, 1'b0, 4'd1, 1'b1);
    checkPipe("drain_wrap.p0", 0, 32'h218);
    tick();
    checkOutput("drain_empty", 2'b00, 1'b0, 4'd0, 1'b1);

    // Enqueue two while dual issuing at count 4
    applyStimulus(2'b11, alu(32'h300), alu(32'h304), 0, 0);
    tick();
    applyStimulus(2'b11, alu(32'h308), alu(32'h30C), 0, 0);
    tick();
    applyStimulus(2'b11, alu(32'h310), alu(32'h314), 1, 0);
    checkOutput("enq_deq", 2'b11, 1'b0, 4'd4, 1'b1);
    checkPipe("enq_deq.p0", 0, 32'h300);
    tick();
    applyStimulus(2'b00, idle, idle, 0, 0);
    checkOutput("enq_deq_after", 2'b11, 1'b0, 4'd4, 1'b1);
    checkPipe("enq_deq_after.p0", 0, 32'h308);
    checkPipe("enq_deq_after.p1", 1, 32'h30C);

    // Flush at count 5 with a concurrent enqueue
    applyStimulus(2'b01, alu(32'h318), junk, 0, 0);
    tick();
    applyStimulus(2'b11, junk, junk, 1, 1);
    checkOutput("flush_comb", 2'b00, 1'b0, 4'd5, 1'b1);
    tick();
    applyStimulus(2'b00, idle, idle, 0, 0);
    checkOutput("flush_next", 2'b00, 1'b0, 4'd0, 1'b1);
    applyStimulus(2'b11, alu(32'h400), alu(32'h404), 0, 0);
    tick();
    applyStimulus(2'b00, idle, idle, 0, 0);
    checkOutput("post_flush", 2'b11, 1'b0, 4'd2, 1'b1);
    checkPipe("post_flush.p0", 0, 32'h400);

    // Asynchronous reset between edges
    #2 reset_i = 1'b1;
    #1;
    checkOutput("mid_reset", 2'b00, 1'b0, 4'd0, 1'b1);
    reset_i = 1'b0;
    tick();
    checkOutput("after_reset", 2'b00, 1'b0, 4'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_buffer.md
Name: issue_buffer

Overview:
- In-order issue queue between decode and the two execute pipes.
- Holds up to DEPTH decoded instructions; accepts up to two per cycle from decode.
- Each cycle it examines the two oldest entries. It issues zero, one or both of them, steering each to pipe 0 or pipe 1 according to ctrl slot constraints and an intra-pair RAW check.
- Decouples fetch/decode stalls from issue; issued entries drive the register-file read addresses downstream.

Parameters:
- DEPTH, 8, queue entries; power of two, minimum 4.
- CTRL_W, width of `CTRL_BUS, decoded control word width.
- XLEN, 32, instruction, PC and predicted-target width.

Ports:
- clock_i  in  1  core clock.
- reset_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous flush from branch resolution; discards all entries.
- enq_valid_i  in  2  per-lane valid; bit0 is the older lane. Bit1 is honoured only with bit0 set.
- enq_entry_i  in  2*ENTRY_W  packed entries {pc, pred_tgt, pred, ctrl, inst}; lane0 in the low half.
- enq_ready_o  out  1  high when free slots are 2 or more.
- iss_ready_i  in  1  execute can accept this cycle; low freezes issue.
- iss_valid_o  out  2  per-pipe valid.
- iss_entry_o  out  2*ENTRY_W  per-pipe entry; pipe0 in the low half.
- iss_swap_o  out  1  high when pipe1 carries the older instruction (dual issue), or when the sole issued instruction is on pipe1.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular array, head/tail pointers of $clog2(DEPTH) bits that wrap naturally, plus an explicit count (avoids full/empty ambiguity).
- Reset (asynchronous, reset_i=1): head=0, tail=0, count=0. Consequently iss_valid_o=0, iss_swap_o=0, enq_ready_o=1, count_o=0. Entry storage is not reset.
- Enqueue: accepted when enq_ready_o && enq_valid_i[0]. Writes lane0 at tail and lane1 (if valid) at tail+1. Tail advances by 1 or 2.
  - enq_valid_i=2'b10 is illegal and is ignored (nothing written).
  - enq_ready_o is combinational from registered count only, with no same-cycle dequeue credit.
- Candidates: A = entry at head (valid if count>=1); B = entry at head+1 (valid if count>=2).
  - Entries written this cycle are not visible until the next cycle: one-cycle minimum enqueue-to-issue latency.
- Slot requirement per entry, from ctrl:
  - ISSUE_PRI=0: ANY.
  - ISSUE_PRI=1 && ISSUE_SLOT=0: P0.
  - ISSUE_PRI=1 && ISSUE_SLOT=1: P1.
- dep: B.ctrl[RS1_ACTIVE] && B.rs1!=0 && B.rs1==A.rd, OR the same for rs2; all ANDed with A.ctrl[REGWRITE].
- Dual issue when A and B are both valid, !dep, and the requirements do not both name the same pipe.
  - Placement: A to pipe1 and B to pipe0 (iss_swap_o=1) if A requires P1 or B requires P0.
  - Otherwise A to pipe0 and B to pipe1.
- Single issue otherwise, when A is valid: A goes to pipe1 if it requires P1, else pipe0. The other pipe's valid is 0.
- B never issues without A (strict in-order).
- Commit: when iss_ready_i=1, head advances by the issued count (0/1/2). When iss_ready_i=0, the outputs still show the candidate selection but head does not move; downstream must ignore them.
- count_next = count + enq_count - deq_count. Simultaneous enqueue and dequeue are legal in the same cycle.
- Full: count==DEPTH or DEPTH-1 gives enq_ready_o=0. Empty: iss_valid_o=0.
- Flush: flush_i=1 forces iss_valid_o=0 combinationally. Next edge: head=tail=0, count=0. Flush wins over a same-cycle enqueue or dequeue.
- Reset asserted mid-operation clears state immediately, independent of clock.
- Pointer and count arithmetic is modulo DEPTH, with no overflow into count.

Decomposition:
- Shared package/defs: ENTRY_W and the field offsets of the packed entry.
  - Slot-requirement encoding: ANY=2'd0, P0=2'd1, P1=2'd2.
  - Existing ctrl macros: ISSUE_PRI, ISSUE_SLOT, REGWRITE, RS1_ACTIVE, RS2_ACTIVE, and the RS1/RS2/RD encodings.
- One natural sub-module: issue_steer. It is combinational and takes A, B, their valids and flush. It returns iss_valid, swap and deq_count. Its pair rules are unit-testable in isolation.

Test Plan:
- Reset, then enqueue two independent ALU ops (ANY, ANY), iss_ready_i=1 -> next cycle iss_valid_o=2'b11, iss_swap_o=0, count returns to 0 the cycle after.
- A = "add x5,x1,x2" (REGWRITE), B = "sub x6,x5,x3" -> only A issues, on pipe0; B issues alone the following cycle; x0 as rd with B reading x0 -> dual issue.
- A requires P1, B is ANY -> dual issue, A on pipe1, B on pipe0, iss_swap_o=1. A and B both require P1 -> only A issues, on pipe1, iss_swap_o=1.
- Fill to DEPTH=8 with iss_ready_i=0 -> enq_ready_o drops at count 7; enq_valid_i=2'b10 writes nothing; pointer wrap across index 7->0 preserves order.
- Simultaneous enqueue of 2 and dual issue at count 4 -> count stays 4.
- flush_i while count=5 and enqueuing -> iss_valid_o=0 that cycle, count=0 next cycle.
- reset_i pulsed mid-stream between clock edges -> count_o=0 and iss_valid_o=0 immediately.
